playfield_scroll_writer: RTL and testbench
==========================================

# playfield_scroll_writer

Video-bus master that delivers playfield horizontal-scroll and playfield-priority register writes to the playfield horizontal logic. It accepts values from the host side, holds the latest pending value for each register, and issues one clean write cycle on VBD during horizontal blank. Each write cycle drives the data, pulses the matching active-low strobe, and holds the data afterwards. The strobe's rising edge, which is where the receiving registers capture, always occurs with stable data.

## Interface
Parameters:
- SETUP_CYC, 1: cycles VBD is driven before the strobe falls (≥1).
- STROBE_CYC, 2: cycles the strobe is held low (≥1).
- HOLD_CYC, 1: cycles VBD is held after the strobe rises (≥1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- hs_valid  in  1  scroll write request.
- hs_data  in  9  horizontal scroll value; bit 8 maps to VBD[8].
- pr_valid  in  1  priority write request.
- pr_data  in  8  priority select byte.
- hblank  in  1  horizontal blank; a write may start only while this is high.
- VBD  out  9  video bus data.
- VBD_oe  out  1  bus drive enable.
- HSCRLD_b  out  1  scroll load strobe, active low.
- PFSPC_b  out  1  priority load strobe, active low.
- busy  out  1  FSM not in IDLE.
- dropped  out  1  one-cycle pulse when a pending unsent value is overwritten.

## Operation
- **Shadow registers.** There are two shadow registers, hs_shadow[8:0] and pr_shadow[7:0], each with a pending flag.
- **Acceptance.** Requests are always accepted; there is no ready signal.
  - On any edge with hs_valid, hs_shadow ← hs_data and hs_pend ← 1. pr_valid behaves the same way for the priority register.
  - If the pending flag was already set and the value is not being captured on that edge, dropped pulses.
  - Simultaneous hs_valid and pr_valid are both accepted; dropped is the OR of the two.
- **FSM states:** IDLE, SETUP, STROBE, HOLD. A single down-counter sets the length of each phase.
- **IDLE → SETUP** when hblank && (hs_pend || pr_pend).
  - If both are pending, scroll is selected first.
  - On that edge: the selected shadow is copied to the bus register, its pending flag clears, and sel records which strobe to use.
  - For a priority write, VBD[8] = 0.
- **Capture-edge collision.** A request arriving on the capture edge re-sets the pending flag with the new value. It is queued for a later cycle and does not pulse dropped.
- **Phase sequence:**
  - SETUP lasts SETUP_CYC cycles with VBD_oe=1 and both strobes high.
  - STROBE lasts STROBE_CYC cycles with the selected strobe low.
  - HOLD lasts HOLD_CYC cycles with the strobes high and VBD unchanged.
  - HOLD → IDLE; VBD_oe drops and VBD returns to 0.
- **hblank falling mid-cycle.** The cycle always completes; hblank is sampled only in IDLE.
- **Strobe exclusivity.** HSCRLD_b and PFSPC_b are never low together, and neither is ever low outside STROBE.
- **Output registers.** All outputs are registered with no combinational paths from inputs.

## Timing
- **Reset values:** VBD=0, VBD_oe=0, HSCRLD_b=1, PFSPC_b=1, busy=0, dropped=0, both pending flags 0, shadows 0, state IDLE.
- **Reset mid-operation.** The cycle aborts at that edge and pending values are discarded.
  - An abort during STROBE produces a strobe rise coincident with VBD→0; the receiver's capture is undefined in that case.
  - The bench checks only the output values in this case.
- **Reference timeline (defaults, idle, hblank high).** Request accepted at edge E0:
  - E1: SETUP, VBD valid, VBD_oe=1.
  - E2: strobe low.
  - E4: strobe high (capture edge).
  - E5: IDLE, VBD_oe=0.
  - Overall: VBD_oe high for SETUP+STROBE+HOLD = 4 cycles; strobe low for exactly STROBE_CYC cycles.
- **Back-to-back writes.** At least one IDLE cycle separates cycles; the next SETUP is entered at E6 at the earliest.
- **Start latency.** When hblank is low, the start is delayed to the first edge on which IDLE sees hblank high.
- **VBD stability.** VBD is constant from the SETUP entry edge through the HOLD exit edge.

## Test plan
- Default parameters, hblank=1, hs_valid with hs_data=0x1A5 at E0 → VBD=0x1A5, VBD_oe=1 during E1–E4; HSCRLD_b low during E2–E3; PFSPC_b stays 1; busy=0 and VBD_oe=0 after E5.
- hblank=0, hs_data=0x055 then pr_data=0xC3 both accepted; raise hblank → scroll cycle (VBD=0x055) first, then priority cycle (VBD=0x0C3, PFSPC_b low), with one IDLE cycle between them; dropped never pulses.
- hblank=0, hs_data=0x010 then hs_data=0x020 → dropped pulses once; after hblank rises, exactly one scroll cycle with VBD=0x020.
- hs_data=0x0FF on the capture edge of an in-flight 0x100 scroll cycle → 0x100 completes; a second cycle with 0x0FF follows; no dropped pulse.
- hblank falls during STROBE → cycle completes with full timing; a pending priority write waits for the next hblank.
- rst asserted during STROBE of a pr_data=0x81 write → the next edge shows all reset values; no further strobe pulses until new requests arrive.

Source files
------------

// File: rtl/playfield_scroll_writer_if.sv
// ---------------------------------------------------------------------------
// playfield_scroll_writer_if
//   Groups the host-side request signals and the video-bus write signals of
//   playfield_scroll_writer.
//   master : the writer (consumes requests and hblank, drives VBD/strobes)
//   slave  : the environment (issues requests, observes the video bus)
//   Signals:
//     hs_valid/hs_data[8:0] : scroll write request and value
//     pr_valid/pr_data[7:0] : priority write request and value
//     hblank                : horizontal blank, writes start only while high
//     VBD[8:0], VBD_oe      : video bus data and drive enable
//     HSCRLD_b, PFSPC_b     : active-low load strobes
//     busy, dropped         : FSM active, pending value overwritten pulse
// ---------------------------------------------------------------------------
interface playfield_scroll_writer_if;
  logic       hs_valid;
  logic [8:0] hs_data;
  logic       pr_valid;
  logic [7:0] pr_data;
  logic       hblank;
  logic [8:0] VBD;
  logic       VBD_oe;
  logic       HSCRLD_b;
  logic       PFSPC_b;
  logic       busy;
  logic       dropped;

  modport master (
    input  hs_valid, hs_data, pr_valid, pr_data, hblank,
    output VBD, VBD_oe, HSCRLD_b, PFSPC_b, busy, dropped
  );

  modport slave (
    output hs_valid, hs_data, pr_valid, pr_data, hblank,
    input  VBD, VBD_oe, HSCRLD_b, PFSPC_b, busy, dropped
  );
endinterface

// File: rtl/playfield_scroll_writer.sv
// ---------------------------------------------------------------------------
// playfield_scroll_writer
//   Video-bus master that writes the playfield horizontal-scroll and the
//   playfield-priority registers during horizontal blank. Host requests are
//   always accepted into one shadow register per target; each pending value
//   is sent as a SETUP / STROBE / HOLD write cycle on VBD so the strobe's
//   rising edge (the receiver's capture point) always sees stable data.
//   Scroll wins when both are pending.
//   Ports:
//     clk  : system clock, all logic on posedge
//     rst  : synchronous active-high reset
//     bus  : playfield_scroll_writer_if.master (requests, hblank, video bus)
//   Parameters:
//     SETUP_CYC  : cycles VBD is driven before the strobe falls (>=1)
//     STROBE_CYC : cycles the strobe is held low (>=1)
//     HOLD_CYC   : cycles VBD is held after the strobe rises (>=1)
// ---------------------------------------------------------------------------
module playfield_scroll_writer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  playfield_scroll_writer_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  // Counter holds phase length minus one, so clog2(MAX_CYC) bits suffice.
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       hs_shadow_q, hs_shadow_d;
  logic             hs_pend_q, hs_pend_d;
  logic [7:0]       pr_shadow_q, pr_shadow_d;
  logic             pr_pend_q, pr_pend_d;
  logic             sel_q, sel_d;            // 1: priority write in flight
  logic [8:0]       vbd_q, vbd_d;
  logic             vbd_oe_q, vbd_oe_d;
  logic             hscrld_b_q, hscrld_b_d;
  logic             pfspc_b_q, pfspc_b_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;

  logic start;
  logic take_hs;
  logic take_pr;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the
    // case/if structure can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hs_shadow_d = hs_shadow_q;
    hs_pend_d   = hs_pend_q;
    pr_shadow_d = pr_shadow_q;
    pr_pend_d   = pr_pend_q;
    sel_d       = sel_q;
    vbd_d       = vbd_q;

    start   = (state_q == S_IDLE) && bus.hblank && (hs_pend_q || pr_pend_q);
    take_hs = start && hs_pend_q;
    take_pr = start && !hs_pend_q && pr_pend_q;

    // A pending value is lost only if it is overwritten without being taken
    // on the same edge.
    dropped_d = (bus.hs_valid && hs_pend_q && !take_hs) ||
                (bus.pr_valid && pr_pend_q && !take_pr);

    // Clear on take first, then accept: a request on the take edge re-arms
    // the pending flag with the new value.
    if (take_hs) hs_pend_d = 1'b0;
    if (take_pr) pr_pend_d = 1'b0;
    if (bus.hs_valid) begin
      hs_shadow_d = bus.hs_data;
      hs_pend_d   = 1'b1;
    end
    if (bus.pr_valid) begin
      pr_shadow_d = bus.pr_data;
      pr_pend_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          sel_d   = take_pr;
          vbd_d   = take_hs ? hs_shadow_q : {1'b0, pr_shadow_q};
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          vbd_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        vbd_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so strobes
    // come straight from flops and never glitch.
    vbd_oe_d   = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
    hscrld_b_d = !((state_d == S_STROBE) && !sel_d);
    pfspc_b_d  = !((state_d == S_STROBE) &&  sel_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hs_shadow_q <= '0;
      hs_pend_q   <= 1'b0;
      pr_shadow_q <= '0;
      pr_pend_q   <= 1'b0;
      sel_q       <= 1'b0;
      vbd_q       <= '0;
      vbd_oe_q    <= 1'b0;
      hscrld_b_q  <= 1'b1;
      pfspc_b_q   <= 1'b1;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hs_shadow_q <= hs_shadow_d;
      hs_pend_q   <= hs_pend_d;
      pr_shadow_q <= pr_shadow_d;
      pr_pend_q   <= pr_pend_d;
      sel_q       <= sel_d;
      vbd_q       <= vbd_d;
      vbd_oe_q    <= vbd_oe_d;
      hscrld_b_q  <= hscrld_b_d;
      pfspc_b_q   <= pfspc_b_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
    end
  end

  assign bus.VBD      = vbd_q;
  assign bus.VBD_oe   = vbd_oe_q;
  assign bus.HSCRLD_b = hscrld_b_q;
  assign bus.PFSPC_b  = pfspc_b_q;
  assign bus.busy     = busy_q;
  assign bus.dropped  = dropped_q;

endmodule

// File: tb/tb_playfield_scroll_writer.sv
// ---------------------------------------------------------------------------
// tb_playfield_scroll_writer
//   Directed bench for playfield_scroll_writer with default parameters.
//   Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_playfield_scroll_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  playfield_scroll_writer_if bus ();

  playfield_scroll_writer #(
    .SETUP_CYC  (1),
    .STROBE_CYC (2),
    .HOLD_CYC   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Background monitors: count dropped pulses and strobe overlaps.
  int drop_cnt = 0;
  int excl_viol = 0;
  always @(negedge clk) begin
    if (bus.dropped === 1'b1) drop_cnt++;
    if (bus.HSCRLD_b === 1'b0 && bus.PFSPC_b === 1'b0) excl_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vbd"},      bus.VBD,      32'h0);
    check({tag, "_oe"},       bus.VBD_oe,   32'h0);
    check({tag, "_hscrld_b"}, bus.HSCRLD_b, 32'h1);
    check({tag, "_pfspc_b"},  bus.PFSPC_b,  32'h1);
    check({tag, "_busy"},     bus.busy,     32'h0);
    check({tag, "_dropped"},  bus.dropped,  32'h0);
  endtask

  // Checks edges E1..E5 of one write cycle whose start edge (E1) is the next
  // rising edge. Request inputs are cleared after E1; hblank is pulled low
  // after edge drop_hb_at (0 = never).
  task automatic check_write(input string tag, input logic [8:0] exp_vbd,
                             input logic is_pr, input int drop_hb_at);
    logic act;
    logic strb;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e == 1) begin
        bus.hs_valid = 1'b0;
        bus.pr_valid = 1'b0;
      end
      if (e == drop_hb_at) bus.hblank = 1'b0;
      act  = (e <= 4);
      strb = (e == 2) || (e == 3);
      check($sformatf("%s_E%0d_vbd", tag, e), bus.VBD,
            act ? {23'd0, exp_vbd} : 32'h0);
      check($sformatf("%s_E%0d_oe", tag, e), bus.VBD_oe, {31'd0, act});
      check($sformatf("%s_E%0d_busy", tag, e), bus.busy, {31'd0, act});
      check($sformatf("%s_E%0d_hscrld_b", tag, e), bus.HSCRLD_b,
            {31'd0, !(strb && !is_pr)});
      check($sformatf("%s_E%0d_pfspc_b", tag, e), bus.PFSPC_b,
            {31'd0, !(strb && is_pr)});
    end
  endtask

  int drop_base;

  initial begin
    bus.hs_valid = 1'b0;
    bus.hs_data  = '0;
    bus.pr_valid = 1'b0;
    bus.pr_data  = '0;
    bus.hblank   = 1'b0;

    // Reset state
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;

    // 1: single scroll write, hblank high
    bus.hblank   = 1'b1;
    bus.hs_valid = 1'b1;
    bus.hs_data  = 9'h1A5;
    step();                                   // E0: request accepted
    bus.hs_valid = 1'b0;
    check("t1_E0_busy", bus.busy, 32'h0);
    check("t1_E0_oe",   bus.VBD_oe, 32'h0);
    check_write("t1", 9'h1A5, 1'b0, 0);
    step();
    check("t1_idle_busy", bus.busy, 32'h0);

    // 2: scroll then priority queued in blank-off, scroll goes first
    drop_base    = drop_cnt;
    bus.hblank   = 1'b0;
    bus.hs_valid = 1'b1;
    bus.hs_data  = 9'h055;
    step();
    bus.hs_valid = 1'b0;
    bus.pr_valid = 1'b1;
    bus.pr_data  = 8'hC3;
    step();
    bus.pr_valid = 1'b0;
    step();
    step();
    check("t2_wait_busy", bus.busy, 32'h0);
    bus.hblank = 1'b1;
    check_write("t2_hs", 9'h055, 1'b0, 0);    // ends on the IDLE edge
    check_write("t2_pr", 9'h0C3, 1'b1, 0);    // SETUP on the following edge
    check("t2_drops", drop_cnt - drop_base, 32'h0);

    // 3: overwrite while pending -> one dropped pulse, only newest value sent
    drop_base    = drop_cnt;
    bus.hblank   = 1'b0;
    bus.hs_valid = 1'b1;
    bus.hs_data  = 9'h010;
    step();
    check("t3_first_dropped", bus.dropped, 32'h0);
    bus.hs_data  = 9'h020;
    step();
    bus.hs_valid = 1'b0;
    check("t3_dropped_pulse", bus.dropped, 32'h1);
    step();
    check("t3_dropped_clear", bus.dropped, 32'h0);
    bus.hblank = 1'b1;
    check_write("t3", 9'h020, 1'b0, 0);
    step();
    step();
    check("t3_no_second_busy", bus.busy, 32'h0);
    check("t3_drops", drop_cnt - drop_base, 32'h1);

    // 4: new request on the edge the pending value is taken
    drop_base    = drop_cnt;
    bus.hblank   = 1'b0;
    bus.hs_valid = 1'b1;
    bus.hs_data  = 9'h100;
    step();
    bus.hs_valid = 1'b0;
    step();
    bus.hblank   = 1'b1;
    bus.hs_valid = 1'b1;
    bus.hs_data  = 9'h0FF;
    check_write("t4_a", 9'h100, 1'b0, 0);
    check_write("t4_b", 9'h0FF, 1'b0, 0);
    check("t4_drops", drop_cnt - drop_base, 32'h0);

    // 5: hblank falls during STROBE; queued priority waits for next blank
    bus.hblank   = 1'b1;
    bus.hs_valid = 1'b1;
    bus.hs_data  = 9'h033;
    bus.pr_valid = 1'b1;
    bus.pr_data  = 8'h5A;
    step();                                   // E0: both accepted
    bus.hs_valid = 1'b0;
    bus.pr_valid = 1'b0;
    check_write("t5_hs", 9'h033, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_wait%0d_busy", i), bus.busy, 32'h0);
      check($sformatf("t5_wait%0d_pfspc_b", i), bus.PFSPC_b, 32'h1);
    end
    bus.hblank = 1'b1;
    check_write("t5_pr", 9'h05A, 1'b1, 0);

    // 6: reset during STROBE of a priority write, with a scroll pending
    bus.pr_valid = 1'b1;
    bus.pr_data  = 8'h81;
    step();                                   // E0
    bus.pr_valid = 1'b0;
    bus.hs_valid = 1'b1;
    bus.hs_data  = 9'h0AA;
    step();                                   // E1: SETUP, scroll now pending
    bus.hs_valid = 1'b0;
    check("t6_E1_vbd", bus.VBD, 32'h081);
    step();                                   // E2: STROBE
    check("t6_E2_pfspc_b", bus.PFSPC_b, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("t6_rst");
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t6_after%0d_busy", i), bus.busy, 32'h0);
      check($sformatf("t6_after%0d_strobes", i),
            {30'd0, bus.HSCRLD_b, bus.PFSPC_b}, 32'h3);
    end

    check("strobe_exclusive", excl_viol, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
